bank_cmd_sched: RTL and testbench
=================================

# bank_cmd_sched

Per-bank command scheduler that converts a simple read/write request stream into the single-cycle ACT/PR/RD/WR/REF strobes, plus row/column address, consumed by the bank timing + BRAM wrapper. It keeps an open-page policy, enforces tRCD/tRP/tRFC/tCL spacing with down-counters, and inserts periodic refresh. It sits between the emulated memory-controller front end and one bank instance, and honours the emulation `halt` freeze.

## Interface
- `ROWS`, 131072, rows per bank; row width `$clog2(ROWS)`
- `COLS`, 1024, columns per row; column width `$clog2(COLS)`
- `TRCD`, 4, ACT→RD/WR spacing in cycles (≥1)
- `TRP`, 4, PR→ACT/REF spacing (≥1)
- `TRFC`, 16, REF→next command spacing (≥1)
- `TCL`, 3, RD→`rd_valid` latency (≥1)
- `TREFI`, 1024, refresh interval; must exceed TRP+TRFC+TRCD+TCL+4
- `clk`  in  1  clock; one clock domain; reset is synchronous and active-high
- `rst`  in  1  synchronous, active-high reset
- `halt`  in  1  emulation freeze; state, counters and outputs held, no strobes
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_we`  in  1  1 = write, 0 = read
- `req_row`  in  `$clog2(ROWS)`  target row
- `req_col`  in  `$clog2(COLS)`  target column
- `ACT`, `PR`, `RD`, `WR`, `REF`  out  1 each  command strobes; at most one high per cycle
- `row`  out  `$clog2(ROWS)`  registered row of the current request
- `column`  out  `$clog2(COLS)`  registered column of the current request
- `rd_valid`  out  1  one-cycle pulse TCL cycles after RD
- `row_open`  out  1  a row is active in the bank

## Operation
- States: IDLE, PRE, WAIT_RP, ACTV, WAIT_RCD, ACCESS, WAIT_CL, REFR, WAIT_RFC.
- `req_ready = (state==IDLE) && !ref_pending && !halt`. This is combinational from registered signals.
- On accept, latch `req_we`, row and column into `row`/`column`, then branch:
  - Hit (open and row equal) → ACCESS.
  - Miss with a row open → PRE.
  - Closed → ACTV.
- PRE: pulse PR, clear open, go to WAIT_RP (TRP−1 cycles). Then go to ACTV, or to REFR if the precharge was for a refresh.
- ACTV: pulse ACT, set open, record open row, go to WAIT_RCD (TRCD−1 cycles), then ACCESS.
- ACCESS:
  - Write: pulse WR and return to IDLE.
  - Read: pulse RD and go to WAIT_CL. `rd_valid` pulses TCL cycles after RD, in the cycle the state returns to IDLE.
- Refresh:
  - The interval counter decrements on every non-halt cycle. At 0 it sets `ref_pending` and reloads TREFI.
  - A second expiry while the refresh is still pending is dropped; refreshes do not stack.
  - In IDLE with `ref_pending`, go to PRE if a row is open, otherwise to REFR.
  - REFR: pulse REF, clear `ref_pending`, go to WAIT_RFC (TRFC−1 cycles), then IDLE with the bank closed.
- Refresh beats a request in the same cycle: `req_ready` is already low once `ref_pending` is set.
- `halt`:
  - Freezes the state, every counter, `ref_pending` and the latched addresses.
  - Command strobes and `rd_valid` are forced low while `halt` is high. A strobe due in a halted cycle is issued on the first unhalted cycle.
- Reset (synchronous, wins over halt):
  - Outputs: all strobes, `rd_valid`, `row_open` and `req_ready` are 0 in the reset cycle; `row`/`column` are 0.
  - State: IDLE, bank closed, `ref_pending` 0, interval counter loaded with TREFI.
  - Reset mid-sequence abandons the request without issuing PR.

## Timing
- Request accepted at cycle t (no halt, no refresh):
  - Hit: RD/WR at t+1.
  - Closed: ACT at t+1, RD/WR at t+1+TRCD.
  - Miss: PR at t+1, ACT at t+1+TRP, RD/WR at t+1+TRP+TRCD.
- `rd_valid` = RD cycle + TCL. `req_ready` rises the cycle after WR, or in the `rd_valid` cycle after a read.
- Refresh: PR (if open) at p, REF at p+TRP, `req_ready` again at REF+TRFC.
- Minimum spacing is exactly the parameter value: a command at cycle c permits the next at c+N.
- `row`/`column` are stable from accept+1 until the next accept.

## Structure
- Package `bank_sched_pkg`: state enum and default timing constants.
- Sub-module `timing_ctr`: loadable down-counter with enable and a `zero` flag. Instantiate it once for the shared wait counter (tRP/tRCD/tRFC/tCL) and once for the tREFI interval.

## Test plan
- Parameters TRCD=4, TRP=4, TCL=3: read row 5 col 9 on a closed bank at t=10 → ACT@11, RD@15, `rd_valid`@18, `row`=5, `column`=9.
- Write row 5 col 10 immediately after → WR one cycle after accept, no ACT/PR.
- Read row 7 with row 5 open, accepted at t → PR@t+1, ACT@t+5, RD@t+9.
- TREFI=64 with row open and an idle front end → PR, then REF 4 cycles later; `req_ready` low until REF+TRFC; `row_open`=0 afterwards.
- `halt` held for 3 cycles between ACT and RD → RD is delayed by exactly 3 cycles; no strobe during halt.
- `rst` asserted during WAIT_RCD → next cycle all outputs 0 and state IDLE; a new read then issues ACT first.

Source files
------------

// File: rtl/bank_sched_pkg.sv
// Shared types and default timing for the per-bank command scheduler.
// The wait-counter helper maps a command spacing onto a down-counter preload.
package bank_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    WAIT_RP,
    ACTV,
    WAIT_RCD,
    ACCESS,
    WAIT_CL,
    REFR,
    WAIT_RFC
  } state_e;

  localparam int DEF_ROWS  = 131072;
  localparam int DEF_COLS  = 1024;
  localparam int DEF_TRCD  = 4;
  localparam int DEF_TRP   = 4;
  localparam int DEF_TRFC  = 16;
  localparam int DEF_TCL   = 3;
  localparam int DEF_TREFI = 1024;

  // A spacing of n puts n-1 cycles in the wait state, and the counter exits on
  // zero, so it is preloaded with n-2. Spacings below 2 skip the wait state.
  function automatic int wait_load(input int n);
    return (n >= 2) ? n - 2 : 0;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bank_cmd_sched_timing_ctr.sv
// Loadable down-counter that stops at zero; en low freezes it completely.
module timing_ctr #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (en) begin
      if (load)
        count <= load_val;
      else if (count != '0)
        count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bank_cmd_sched.sv
// Open-page command scheduler for one bank: turns read/write requests into
// ACT/PR/RD/WR/REF strobes with tRCD/tRP/tRFC/tCL spacing and periodic refresh.
module bank_cmd_sched
  import bank_sched_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int TRCD  = DEF_TRCD,
  parameter int TRP   = DEF_TRP,
  parameter int TRFC  = DEF_TRFC,
  parameter int TCL   = DEF_TCL,
  parameter int TREFI = DEF_TREFI
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(ROWS)-1:0]  req_row,
  input  logic [$clog2(COLS)-1:0]  req_col,
  output logic                     ACT,
  output logic                     PR,
  output logic                     RD,
  output logic                     WR,
  output logic                     REF,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic [$clog2(COLS)-1:0]  column,
  output logic                     rd_valid,
  output logic                     row_open
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int WW = $clog2(max4(TRP, TRCD, TRFC, TCL) + 1);
  localparam int IW = $clog2(TREFI + 1);

  state_e        state, state_nxt;
  logic          run, accept, hit;
  logic          wait_ld, wait_zero, ref_zero;
  logic [WW-1:0] wait_ld_val;
  logic          open, we, ref_pending, ref_pre, rd_flag;
  logic [RW-1:0] open_row, row_q;
  logic [CW-1:0] col_q;

  assign run       = !halt;
  assign req_ready = (state == IDLE) && !ref_pending && !halt && !rst;
  assign accept    = req_valid && req_ready;
  assign hit       = open && (req_row == open_row);

  timing_ctr #(.W(WW), .RST_VAL('0)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .load     (wait_ld),
    .load_val (wait_ld_val),
    .zero     (wait_zero)
  );

  // Reloads itself on expiry, so one refresh request is raised per interval.
  timing_ctr #(.W(IW), .RST_VAL(IW'(TREFI))) u_refi (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .load     (ref_zero),
    .load_val (IW'(TREFI)),
    .zero     (ref_zero)
  );

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (run) state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ref_pending)  state_nxt = open ? PRE : REFR;
        else if (accept)  state_nxt = hit ? ACCESS : (open ? PRE : ACTV);
      end
      PRE:      state_nxt = (TRP >= 2) ? WAIT_RP : (ref_pre ? REFR : ACTV);
      WAIT_RP:  if (wait_zero) state_nxt = ref_pre ? REFR : ACTV;
      ACTV:     state_nxt = (TRCD >= 2) ? WAIT_RCD : ACCESS;
      WAIT_RCD: if (wait_zero) state_nxt = ACCESS;
      ACCESS:   state_nxt = (!we && TCL >= 2) ? WAIT_CL : IDLE;
      WAIT_CL:  if (wait_zero) state_nxt = IDLE;
      REFR:     state_nxt = (TRFC >= 2) ? WAIT_RFC : IDLE;
      WAIT_RFC: if (wait_zero) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes and wait-counter preloads are decoded from the command states;
  // a halted cycle simply re-presents the same state on the next free cycle.
  always_comb begin
    ACT         = 1'b0;
    PR          = 1'b0;
    RD          = 1'b0;
    WR          = 1'b0;
    REF         = 1'b0;
    wait_ld     = 1'b0;
    wait_ld_val = '0;
    if (!rst && run) begin
      unique case (state)
        PRE: begin
          PR          = 1'b1;
          wait_ld     = 1'b1;
          wait_ld_val = WW'(wait_load(TRP));
        end
        ACTV: begin
          ACT         = 1'b1;
          wait_ld     = 1'b1;
          wait_ld_val = WW'(wait_load(TRCD));
        end
        ACCESS: begin
          if (we) begin
            WR = 1'b1;
          end else begin
            RD          = 1'b1;
            wait_ld     = 1'b1;
            wait_ld_val = WW'(wait_load(TCL));
          end
        end
        REFR: begin
          REF         = 1'b1;
          wait_ld     = 1'b1;
          wait_ld_val = WW'(wait_load(TRFC));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open        <= 1'b0;
      open_row    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      we          <= 1'b0;
      ref_pending <= 1'b0;
      ref_pre     <= 1'b0;
      rd_flag     <= 1'b0;
    end else if (run) begin
      if (ref_zero)            ref_pending <= 1'b1;
      else if (state == REFR)  ref_pending <= 1'b0;
      if (accept) begin
        row_q <= req_row;
        col_q <= req_col;
        we    <= req_we;
      end
      // Remembers whether the coming precharge belongs to a refresh.
      if (state == IDLE) ref_pre <= ref_pending;
      if (state == PRE || state == REFR) open <= 1'b0;
      if (state == ACTV) begin
        open     <= 1'b1;
        open_row <= row_q;
      end
      rd_flag <= (state == ACCESS && !we && TCL < 2) || (state == WAIT_CL && wait_zero);
    end
  end

  assign rd_valid = rd_flag && run && !rst;
  assign row_open = open && !rst;
  assign row      = rst ? '0 : row_q;
  assign column   = rst ? '0 : col_q;

endmodule

// File: tb/tb_bank_cmd_sched.sv
// Scoreboard bench for bank_cmd_sched: each scenario queues the strobes it
// expects, a negedge monitor collects what the DUT issues, and the two are drained.
module tb_bank_cmd_sched;

  localparam int ROWS  = 131072;
  localparam int COLS  = 1024;
  localparam int TRCD  = 4;
  localparam int TRP   = 4;
  localparam int TRFC  = 16;
  localparam int TCL   = 3;
  localparam int TREFI = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        ACT, PR, RD, WR, REF;
  logic [16:0] row;
  logic [9:0]  column;
  logic        rd_valid;
  logic        row_open;

  bank_cmd_sched #(
    .ROWS(ROWS), .COLS(COLS), .TRCD(TRCD), .TRP(TRP),
    .TRFC(TRFC), .TCL(TCL), .TREFI(TREFI)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_row   (req_row),
    .req_col   (req_col),
    .ACT       (ACT),
    .PR        (PR),
    .RD        (RD),
    .WR        (WR),
    .REF       (REF),
    .row       (row),
    .column    (column),
    .rd_valid  (rd_valid),
    .row_open  (row_open)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_ACT, EV_PR, EV_RD, EV_WR, EV_REF, EV_RDV} ev_kind_e;
  typedef struct {
    int       cyc;
    ev_kind_e kind;
    int       row;
    int       col;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  multi_cnt = 0;
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  r_cyc     = 0;

  function automatic ev_t mk(input int c, input ev_kind_e k, input int r, input int cl);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.row  = r;
    e.col  = cl;
    return e;
  endfunction

  always @(negedge clk) begin
    if ((int'(ACT === 1'b1) + int'(PR === 1'b1) + int'(RD === 1'b1) +
         int'(WR === 1'b1) + int'(REF === 1'b1)) > 1)
      multi_cnt++;
    if (ACT === 1'b1)      obs_q.push_back(mk(cyc, EV_ACT, int'(row), int'(column)));
    if (PR === 1'b1)       obs_q.push_back(mk(cyc, EV_PR,  int'(row), int'(column)));
    if (RD === 1'b1)       obs_q.push_back(mk(cyc, EV_RD,  int'(row), int'(column)));
    if (WR === 1'b1)       obs_q.push_back(mk(cyc, EV_WR,  int'(row), int'(column)));
    if (REF === 1'b1)      obs_q.push_back(mk(cyc, EV_REF, int'(row), int'(column)));
    if (rd_valid === 1'b1) obs_q.push_back(mk(cyc, EV_RDV, int'(row), int'(column)));
  end

  task automatic expect_ev(input int c, input ev_kind_e k, input int r, input int cl);
    exp_q.push_back(mk(c, k, r, cl));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r_cyc = cyc;
  endtask

  task automatic issue(input logic we, input int r, input int cl, output int t);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_row   = 17'(r);
    req_col   = 10'(cl);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        t = cyc;
        break;
      end
    end
    n_checks++;
    if (t < 0) begin
      n_fail++;
      $display("FAIL accept_timeout: request row %0d col %0d never accepted within 200 cycles", r, cl);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic scoreboard_drain(input string tag);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_missing: got no event, expected %s@%0d row %0d col %0d",
                 tag, e.kind.name(), e.cyc, e.row, e.col);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.row !== e.row || o.col !== e.col) begin
          n_fail++;
          $display("FAIL %s_event: got %s@%0d row %0d col %0d, expected %s@%0d row %0d col %0d",
                   tag, o.kind.name(), o.cyc, o.row, o.col, e.kind.name(), e.cyc, e.row, e.col);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      o = obs_q[0];
      $display("FAIL %s_extra: got %0d unexpected events (first %s@%0d), expected 0",
               tag, obs_q.size(), o.kind.name(), o.cyc);
    end
    obs_q.delete();
    n_checks++;
    if (multi_cnt != 0) begin
      n_fail++;
      $display("FAIL %s_one_hot: got %0d cycles with several strobes, expected 0", tag, multi_cnt);
    end
    multi_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ACT, PR, RD, WR, REF, rd_valid, row_open, req_ready} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {ACT, PR, RD, WR, REF, rd_valid, row_open, req_ready});
    end
    n_checks++;
    if (row !== '0 || column !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got row %0d col %0d, expected 0 0", row, column);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || row_open !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got ready %b open %b, expected 1 0", req_ready, row_open);
    end
    obs_q.delete();
    multi_cnt = 0;
  endtask

  task automatic test_closed_read_then_write();
    int t, t2;
    do_reset();
    issue(1'b0, 5, 9, t);
    expect_ev(t + 1, EV_ACT, 5, 9);
    expect_ev(t + 1 + TRCD, EV_RD, 5, 9);
    expect_ev(t + 1 + TRCD + TCL, EV_RDV, 5, 9);
    issue(1'b1, 5, 10, t2);
    n_checks++;
    if (t2 !== t + 1 + TRCD + TCL) begin
      n_fail++;
      $display("FAIL ready_in_rd_valid_cycle: got accept@%0d, expected %0d", t2, t + 1 + TRCD + TCL);
    end
    expect_ev(t2 + 1, EV_WR, 5, 10);
    wait_until(t2 + 3);
    n_checks++;
    if (row !== 17'd5 || column !== 10'd10 || row_open !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_addr: got row %0d col %0d open %b, expected 5 10 1", row, column, row_open);
    end
    scoreboard_drain("closed_read_write");
  endtask

  task automatic test_read_miss();
    int t, t2;
    do_reset();
    issue(1'b1, 5, 0, t);
    expect_ev(t + 1, EV_ACT, 5, 0);
    expect_ev(t + 1 + TRCD, EV_WR, 5, 0);
    issue(1'b0, 7, 3, t2);
    n_checks++;
    if (t2 !== t + 2 + TRCD) begin
      n_fail++;
      $display("FAIL ready_after_wr: got accept@%0d, expected %0d", t2, t + 2 + TRCD);
    end
    expect_ev(t2 + 1, EV_PR, 7, 3);
    expect_ev(t2 + 1 + TRP, EV_ACT, 7, 3);
    expect_ev(t2 + 1 + TRP + TRCD, EV_RD, 7, 3);
    expect_ev(t2 + 1 + TRP + TRCD + TCL, EV_RDV, 7, 3);
    wait_until(t2 + 3 + TRP + TRCD + TCL);
    n_checks++;
    if (row !== 17'd7 || row_open !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_row: got row %0d open %b, expected 7 1", row, row_open);
    end
    scoreboard_drain("read_miss");
  endtask

  task automatic test_refresh();
    int ta, tb, pr_c, ref_c;
    do_reset();
    issue(1'b1, 3, 1, ta);
    expect_ev(ta + 1, EV_ACT, 3, 1);
    expect_ev(ta + 1 + TRCD, EV_WR, 3, 1);
    // interval counter holds TREFI in cycle r_cyc and expires TREFI cycles later
    pr_c  = r_cyc + TREFI + 2;
    ref_c = pr_c + TRP;
    wait_until(r_cyc + TREFI);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_refresh: got %b, expected 1", req_ready);
    end
    issue(1'b0, 8, 2, tb);
    n_checks++;
    if (tb !== ref_c + TRFC) begin
      n_fail++;
      $display("FAIL refresh_blocks_request: got accept@%0d, expected %0d", tb, ref_c + TRFC);
    end
    expect_ev(pr_c, EV_PR, 3, 1);
    expect_ev(ref_c, EV_REF, 3, 1);
    expect_ev(tb + 1, EV_ACT, 8, 2);
    expect_ev(tb + 1 + TRCD, EV_RD, 8, 2);
    expect_ev(tb + 1 + TRCD + TCL, EV_RDV, 8, 2);
    @(negedge clk);
    n_checks++;
    if (row_open !== 1'b0) begin
      n_fail++;
      $display("FAIL closed_after_refresh: got row_open %b, expected 0", row_open);
    end
    wait_until(tb + 3 + TRCD + TCL);
    scoreboard_drain("refresh");
  endtask

  task automatic test_halt();
    int t, t2;
    do_reset();
    issue(1'b0, 2, 4, t);
    @(posedge clk); #1 halt = 1'b1;
    repeat (3) @(posedge clk);
    #1 halt = 1'b0;
    expect_ev(t + 1, EV_ACT, 2, 4);
    expect_ev(t + 1 + TRCD + 3, EV_RD, 2, 4);
    expect_ev(t + 1 + TRCD + 3 + TCL, EV_RDV, 2, 4);
    wait_until(t + 2 + TRCD + 3 + TCL);
    issue(1'b0, 2, 5, t2);
    expect_ev(t2 + 1, EV_RD, 2, 5);
    repeat (2) @(posedge clk);
    // the cycle rd_valid would pulse in is frozen
    @(posedge clk); #1 halt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_during_halt: got %b, expected 0", req_ready);
    end
    @(posedge clk); #1 halt = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_halt: got %b, expected 1", req_ready);
    end
    expect_ev(t2 + 1 + TCL + 1, EV_RDV, 2, 5);
    wait_until(t2 + TCL + 4);
    scoreboard_drain("halt");
  endtask

  task automatic test_reset_mid_sequence();
    int t, t4;
    do_reset();
    issue(1'b0, 6, 1, t);
    expect_ev(t + 1, EV_ACT, 6, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ACT, PR, RD, WR, REF, rd_valid, row_open, req_ready} !== 8'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b, expected 00000000",
               {ACT, PR, RD, WR, REF, rd_valid, row_open, req_ready});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (row !== '0 || column !== '0 || row_open !== 1'b0 || req_ready !== 1'b1 ||
        {ACT, PR, RD, WR, REF, rd_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL after_mid_reset: got row %0d col %0d open %b ready %b strobes %b, expected 0 0 0 1 000000",
               row, column, row_open, req_ready, {ACT, PR, RD, WR, REF, rd_valid});
    end
    issue(1'b0, 6, 1, t4);
    expect_ev(t4 + 1, EV_ACT, 6, 1);
    expect_ev(t4 + 1 + TRCD, EV_RD, 6, 1);
    expect_ev(t4 + 1 + TRCD + TCL, EV_RDV, 6, 1);
    wait_until(t4 + 3 + TRCD + TCL);
    scoreboard_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_closed_read_then_write();
    test_read_miss();
    test_refresh();
    test_halt();
    test_reset_mid_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
